spi_master: RTL and testbench

//  SPI mode-0 bus master: byte-stream initiator toward spi_slave. Drives nCS/SCK/MOSI, samples MISO.

---
 rtl/spi_master_if.sv | 37 +++
 rtl/spi_master.sv | 244 ++++++++++++++++++++++++
 tb/tb_spi_master.sv | 387 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_master_if.sv
`default_nettype none
// ============================================================================
//  Module      : spi_master_if
//  Description : Bundle of the byte-stream handshake (tx/rx valid-ready side)
//                and the four SPI pins used by spi_master.
//                master modport : view taken by spi_master itself
//                slave  modport : view taken by the system/pin side
//  Signals     : tx_data[7:0], tx_last, tx_valid, tx_ready,
//                rx_data[7:0], rx_last, rx_valid, busy,
//                nCS, SCK, MOSI, MISO
//  Revision    : 1.0 - initial release
// ============================================================================
interface spi_master_if;
    logic [7:0] tx_data;
    logic       tx_last;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_last;
    logic       rx_valid;
    logic       busy;
    logic       nCS;
    logic       SCK;
    logic       MOSI;
    logic       MISO;

    modport master (
        input  tx_data, tx_last, tx_valid, MISO,
        output tx_ready, rx_data, rx_last, rx_valid, busy, nCS, SCK, MOSI
    );

    modport slave (
        output tx_data, tx_last, tx_valid, MISO,
        input  tx_ready, rx_data, rx_last, rx_valid, busy, nCS, SCK, MOSI
    );
endinterface
`default_nettype wire

// File: rtl/spi_master.sv
`default_nettype none
// ============================================================================
//  Module      : spi_master
//  Description : SPI mode-0 bus master. Takes a valid/ready byte stream,
//                frames it with nCS (byte flagged tx_last closes the
//                transfer), shifts it out on MOSI while sampling MISO, and
//                returns each received byte as a one-cycle rx_valid strobe.
//  Ports       : clk    - system clock
//                nreset - asynchronous active-low reset
//                bus    - spi_master_if.master (handshake + SPI pins)
//  Parameters  : CLK_DIV  clk cycles per SCK half-period (>=2)
//                CS_SETUP clk cycles nCS low before first SCK phase (>=1)
//                CS_HOLD  clk cycles after closing byte before nCS rise (>=1)
//                CS_IDLE  min clk cycles nCS high between transfers (>=1)
//  Config      : define SPI_MASTER_LSB_FIRST_EN for LSB-first bit order in
//                both directions; default is MSB first.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_master #(
    parameter int CLK_DIV  = 2,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int CS_IDLE  = 2
) (
    input  logic         clk,
    input  logic         nreset,
    spi_master_if.master bus
);

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    localparam logic [2:0] C_IDLE  = 3'd0;
    localparam logic [2:0] C_SETUP = 3'd1;
    localparam logic [2:0] C_LO    = 3'd2;
    localparam logic [2:0] C_HI    = 3'd3;
    localparam logic [2:0] C_WAIT  = 3'd4;
    localparam logic [2:0] C_HOLD  = 3'd5;
    localparam logic [2:0] C_GAP   = 3'd6;

    // One phase counter serves SETUP, LO, HI, HOLD and GAP; each phase
    // reloads it to zero and ends when it reaches its terminal value.
    localparam int         C_CNT_W      = 16;
    localparam logic [C_CNT_W-1:0] C_DIV_LAST   = C_CNT_W'(CLK_DIV - 1);
    localparam logic [C_CNT_W-1:0] C_SETUP_LAST = C_CNT_W'(CS_SETUP - 1);
    localparam logic [C_CNT_W-1:0] C_HOLD_LAST  = C_CNT_W'(CS_HOLD - 1);
    localparam logic [C_CNT_W-1:0] C_IDLE_LAST  = C_CNT_W'(CS_IDLE - 1);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [2:0]         r_state;
    logic [C_CNT_W-1:0] r_cnt;
    logic [2:0]         r_bit_cnt;
    logic [7:0]         r_tx_byte;
    logic [7:0]         r_rx_shift;
    logic               r_last;

    logic               r_ncs;
    logic               r_sck;
    logic               r_mosi;
    logic               r_tx_ready;
    logic               r_rx_valid;
    logic               r_rx_last;
    logic [7:0]         r_rx_data;
    logic               r_busy;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic       w_accept;
    logic       w_first_bit;
    logic [2:0] w_cur_idx;
    logic [2:0] w_next_idx;
    logic [7:0] w_rx_next;

    assign w_accept = bus.tx_valid & r_tx_ready;

    // The bit counter always runs 7 down to 0; the bit order only changes
    // which byte position that count maps to (7-x == ~x for 3 bits).
`ifdef SPI_MASTER_LSB_FIRST_EN
    assign w_first_bit = bus.tx_data[0];
    assign w_cur_idx   = ~r_bit_cnt;
    assign w_next_idx  = ~(r_bit_cnt - 3'd1);
`else
    assign w_first_bit = bus.tx_data[7];
    assign w_cur_idx   = r_bit_cnt;
    assign w_next_idx  = r_bit_cnt - 3'd1;
`endif

    // Receive byte with the bit being sampled this cycle merged in. Every
    // position is rewritten once per byte, so stale bits never leak out.
    always_comb begin
        w_rx_next            = r_rx_shift;
        w_rx_next[w_cur_idx] = bus.MISO;
    end

    // ------------------------------------------------------------------
    // Main FSM and all registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state    <= C_IDLE;
            r_cnt      <= '0;
            r_bit_cnt  <= 3'd0;
            r_tx_byte  <= 8'h00;
            r_rx_shift <= 8'h00;
            r_last     <= 1'b0;
            r_ncs      <= 1'b1;
            r_sck      <= 1'b0;
            r_mosi     <= 1'b0;
            r_tx_ready <= 1'b0;
            r_rx_valid <= 1'b0;
            r_rx_last  <= 1'b0;
            r_rx_data  <= 8'h00;
            r_busy     <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;

            case (r_state)
                C_IDLE: begin
                    r_tx_ready <= 1'b1;
                    if (w_accept) begin
                        r_tx_byte  <= bus.tx_data;
                        r_last     <= bus.tx_last;
                        r_mosi     <= w_first_bit;
                        r_ncs      <= 1'b0;
                        r_tx_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_bit_cnt  <= 3'd7;
                        r_cnt      <= '0;
                        r_state    <= C_SETUP;
                    end
                end

                C_SETUP: begin
                    if (r_cnt == C_SETUP_LAST) begin
                        r_cnt   <= '0;
                        r_state <= C_LO;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                C_LO: begin
                    if (r_cnt == C_DIV_LAST) begin
                        r_cnt   <= '0;
                        r_sck   <= 1'b1;
                        r_state <= C_HI;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                C_HI: begin
                    if (r_cnt == C_DIV_LAST) begin
                        // Sample MISO in the same cycle SCK is driven low:
                        // the slave has had a full high phase to settle.
                        r_cnt      <= '0;
                        r_sck      <= 1'b0;
                        r_rx_shift <= w_rx_next;
                        if (r_bit_cnt == 3'd0) begin
                            r_rx_valid <= 1'b1;
                            r_rx_data  <= w_rx_next;
                            r_rx_last  <= r_last;
                            // Ready already in the strobe cycle so a held
                            // tx_valid continues without an extra stall.
                            r_tx_ready <= ~r_last;
                            r_state    <= C_WAIT;
                        end else begin
                            r_bit_cnt <= r_bit_cnt - 3'd1;
                            r_mosi    <= r_tx_byte[w_next_idx];
                            r_state   <= C_LO;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                C_WAIT: begin
                    if (r_last) begin
                        r_tx_ready <= 1'b0;
                        r_cnt      <= '0;
                        r_state    <= C_HOLD;
                    end else if (w_accept) begin
                        r_tx_byte  <= bus.tx_data;
                        r_last     <= bus.tx_last;
                        r_mosi     <= w_first_bit;
                        r_tx_ready <= 1'b0;
                        r_bit_cnt  <= 3'd7;
                        r_cnt      <= '0;
                        r_state    <= C_LO;
                    end
                end

                C_HOLD: begin
                    if (r_cnt == C_HOLD_LAST) begin
                        r_ncs   <= 1'b1;
                        r_mosi  <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= C_GAP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                C_GAP: begin
                    if (r_cnt == C_IDLE_LAST) begin
                        r_cnt      <= '0;
                        r_busy     <= 1'b0;
                        r_tx_ready <= 1'b1;
                        r_state    <= C_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                default: begin
                    r_state    <= C_IDLE;
                    r_cnt      <= '0;
                    r_ncs      <= 1'b1;
                    r_sck      <= 1'b0;
                    r_mosi     <= 1'b0;
                    r_tx_ready <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.nCS      = r_ncs;
    assign bus.SCK      = r_sck;
    assign bus.MOSI     = r_mosi;
    assign bus.tx_ready = r_tx_ready;
    assign bus.rx_valid = r_rx_valid;
    assign bus.rx_last  = r_rx_last;
    assign bus.rx_data  = r_rx_data;
    assign bus.busy     = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_spi_master.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_spi_master
//  Description : Directed self-checking bench for spi_master. MISO is either
//                looped back from MOSI or driven by a small slave model that
//                returns a fixed byte MSB first.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_master;

    localparam int CLK_DIV  = 2;
    localparam int CS_SETUP = 2;
    localparam int CS_HOLD  = 2;
    localparam int CS_IDLE  = 2;
    // nCS low time of a one-byte transfer: setup, 8 bits, WAIT cycle, hold
    localparam int T_ONE    = CS_SETUP + 16*CLK_DIV + 1 + CS_HOLD;   // 37
    localparam int T_TWO    = CS_SETUP + 2*(16*CLK_DIV + 1) + CS_HOLD; // 70

    logic clk    = 1'b0;
    logic nreset = 1'b0;

    spi_master_if bus();

    spi_master #(
        .CLK_DIV  (CLK_DIV),
        .CS_SETUP (CS_SETUP),
        .CS_HOLD  (CS_HOLD),
        .CS_IDLE  (CS_IDLE)
    ) dut (
        .clk    (clk),
        .nreset (nreset),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- MISO source: loopback or fixed-pattern slave -------
    logic       slave_mode = 1'b0;
    logic [7:0] slv_pat    = 8'h5A;
    logic [2:0] slv_idx    = 3'd0;
    logic       slv_sck_q  = 1'b0;

    always @(negedge clk) begin
        if (bus.nCS) slv_idx <= 3'd0;
        else if (slv_sck_q && !bus.SCK) slv_idx <= slv_idx + 3'd1;
        slv_sck_q <= bus.SCK;
    end

    assign bus.MISO = slave_mode ? slv_pat[~slv_idx] : bus.MOSI;

    // ---------------- Pin / stream monitor --------------------------------
    logic       sck_q = 1'b0;
    logic       ncs_q = 1'b1;
    logic       mosi_q = 1'b0;
    int         sck_rises = 0;
    int         ncs_falls = 0;
    int         mosi_unstable = 0;
    int         low_run = 0, high_run = 0;
    int         last_low_run = 0, last_high_run = 0;
    int         since_fall = 0, fall_to_rise = 0;
    logic       first_pending = 1'b0;
    logic       first_mosi = 1'b0;
    logic [7:0] mosi_cap = 8'h00;
    int         rx_cnt = 0;
    logic [8:0] rx_log [0:255];

    always @(negedge clk) begin
        sck_q  <= bus.SCK;
        ncs_q  <= bus.nCS;
        mosi_q <= bus.MOSI;
        if (bus.SCK && !sck_q) begin
            sck_rises <= sck_rises + 1;
            mosi_cap  <= {mosi_cap[6:0], bus.MOSI};
            if (bus.MOSI !== mosi_q) mosi_unstable <= mosi_unstable + 1;
            if (first_pending) begin
                first_mosi    <= bus.MOSI;
                first_pending <= 1'b0;
            end
        end
        if (!bus.SCK && sck_q) since_fall <= 0;
        else                   since_fall <= since_fall + 1;
        if (!bus.nCS) begin
            low_run <= low_run + 1;
            if (ncs_q) begin
                ncs_falls     <= ncs_falls + 1;
                last_high_run <= high_run;
                high_run      <= 0;
                first_pending <= 1'b1;
            end
        end else begin
            high_run <= high_run + 1;
            if (!ncs_q) begin
                last_low_run <= low_run;
                low_run      <= 0;
                fall_to_rise <= since_fall + 1;
            end
        end
        if (bus.rx_valid) begin
            rx_log[rx_cnt[7:0]] <= {bus.rx_last, bus.rx_data};
            rx_cnt <= rx_cnt + 1;
        end
    end

    // ---------------- Stimulus helpers ------------------------------------
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d, input logic l);
        int   n;
        logic rdy;
        bus.tx_data  = d;
        bus.tx_last  = l;
        bus.tx_valid = 1'b1;
        n   = 0;
        rdy = 1'b0;
        while (!rdy && n < 400) begin
            rdy = bus.tx_ready;
            step();
            n++;
        end
        checks++;
        if (!rdy) begin
            errors++;
            $display("FAIL push_accept: tx_ready=%b after %0d clk, required 1", rdy, n);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.busy !== 1'b0 && n < 600) begin
            step();
            n++;
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL wait_idle: busy=%b after %0d clk, required 0", bus.busy, n);
        end
    endtask

    // ---------------- Tests -----------------------------------------------
    task automatic test_reset();
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
        bus.tx_last  = 1'b0;
        nreset = 1'b0;
        repeat (3) step();
        checks++;
        if ({bus.nCS, bus.SCK, bus.MOSI, bus.busy} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_pins: nCS/SCK/MOSI/busy=%b required 1000",
                     {bus.nCS, bus.SCK, bus.MOSI, bus.busy});
        end
        checks++;
        if ({bus.tx_ready, bus.rx_valid, bus.rx_last, bus.rx_data} !== 11'h000) begin
            errors++;
            $display("FAIL reset_stream: ready/rxv/rxl/rxd=%h required 000",
                     {bus.tx_ready, bus.rx_valid, bus.rx_last, bus.rx_data});
        end
        nreset = 1'b1;
        #1;
        checks++;
        if (bus.tx_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready_release: tx_ready=%b required 0", bus.tx_ready);
        end
        step();
        checks++;
        if (bus.tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready_first_clk: tx_ready=%b required 1", bus.tx_ready);
        end
    endtask

    task automatic test_single();
        int s0, r0, m0;
        s0 = sck_rises; r0 = rx_cnt; m0 = mosi_unstable;
        push(8'hA5, 1'b1);
        bus.tx_valid = 1'b0;
        wait_idle();
        checks++;
        if (sck_rises - s0 !== 8) begin
            errors++;
            $display("FAIL single_sck: pulses=%0d required 8", sck_rises - s0);
        end
        checks++;
        if (rx_cnt - r0 !== 1 || rx_log[r0[7:0]] !== {1'b1, 8'hA5}) begin
            errors++;
            $display("FAIL single_rx: count=%0d last/data=%h required 1 and 1a5",
                     rx_cnt - r0, rx_log[r0[7:0]]);
        end
        checks++;
        if (last_low_run !== T_ONE) begin
            errors++;
            $display("FAIL single_ncs_low: %0d clk required %0d", last_low_run, T_ONE);
        end
        checks++;
        if (mosi_unstable - m0 !== 0 || mosi_cap !== 8'hA5) begin
            errors++;
            $display("FAIL single_mosi: unstable=%0d bits=%h required 0 and a5",
                     mosi_unstable - m0, mosi_cap);
        end
    endtask

    task automatic test_back_to_back();
        int s0, r0, f0;
        s0 = sck_rises; r0 = rx_cnt; f0 = ncs_falls;
        push(8'h3C, 1'b0);
        push(8'hC3, 1'b1);
        bus.tx_valid = 1'b0;
        wait_idle();
        checks++;
        if (ncs_falls - f0 !== 1 || last_low_run !== T_TWO) begin
            errors++;
            $display("FAIL b2b_ncs: falls=%0d low=%0d required 1 and %0d",
                     ncs_falls - f0, last_low_run, T_TWO);
        end
        checks++;
        if (sck_rises - s0 !== 16) begin
            errors++;
            $display("FAIL b2b_sck: pulses=%0d required 16", sck_rises - s0);
        end
        checks++;
        if (rx_cnt - r0 !== 2 || rx_log[r0[7:0]] !== {1'b0, 8'h3C}
            || rx_log[8'(r0 + 1)] !== {1'b1, 8'hC3}) begin
            errors++;
            $display("FAIL b2b_rx: count=%0d bytes=%h %h required 2, 03c 1c3",
                     rx_cnt - r0, rx_log[r0[7:0]], rx_log[8'(r0 + 1)]);
        end
    endtask

    task automatic test_stall();
        int   r0, f0, n, bad;
        r0 = rx_cnt; f0 = ncs_falls;
        push(8'h01, 1'b0);
        bus.tx_valid = 1'b0;
        n = 0;
        while (bus.tx_ready !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if ({bus.nCS, bus.SCK, bus.tx_ready} !== 3'b001) bad++;
            step();
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL stall_hold: %0d of 20 clk not nCS=0/SCK=0/ready=1, required 0", bad);
        end
        push(8'h80, 1'b1);
        bus.tx_valid = 1'b0;
        wait_idle();
        checks++;
        if (rx_cnt - r0 !== 2 || rx_log[r0[7:0]] !== {1'b0, 8'h01}
            || rx_log[8'(r0 + 1)] !== {1'b1, 8'h80}) begin
            errors++;
            $display("FAIL stall_rx: count=%0d bytes=%h %h required 2, 001 180",
                     rx_cnt - r0, rx_log[r0[7:0]], rx_log[8'(r0 + 1)]);
        end
        // closing byte: one WAIT cycle then CS_HOLD before nCS rises
        checks++;
        if (ncs_falls - f0 !== 1 || fall_to_rise !== CS_HOLD + 1) begin
            errors++;
            $display("FAIL stall_hold_time: falls=%0d sck_fall->ncs_rise=%0d required 1 and %0d",
                     ncs_falls - f0, fall_to_rise, CS_HOLD + 1);
        end
    endtask

    task automatic test_slave();
        int r0, m0;
        r0 = rx_cnt; m0 = mosi_unstable;
        slave_mode = 1'b1;
        push(8'hFF, 1'b1);
        bus.tx_valid = 1'b0;
        wait_idle();
        slave_mode = 1'b0;
        checks++;
        if (rx_cnt - r0 !== 1 || rx_log[r0[7:0]] !== {1'b1, 8'h5A}) begin
            errors++;
            $display("FAIL slave_rx: count=%0d last/data=%h required 1 and 15a",
                     rx_cnt - r0, rx_log[r0[7:0]]);
        end
        checks++;
        if (mosi_unstable - m0 !== 0 || mosi_cap !== 8'hFF) begin
            errors++;
            $display("FAIL slave_mosi: unstable=%0d bits=%h required 0 and ff",
                     mosi_unstable - m0, mosi_cap);
        end
    endtask

    task automatic test_gap();
        int   r0, f0;
        logic exp_first;
`ifdef SPI_MASTER_LSB_FIRST_EN
        exp_first = 1'b1;
`else
        exp_first = 1'b0;
`endif
        r0 = rx_cnt; f0 = ncs_falls;
        push(8'h01, 1'b1);
        push(8'h01, 1'b1);
        bus.tx_valid = 1'b0;
        wait_idle();
        checks++;
        if (ncs_falls - f0 !== 2 || last_high_run < CS_IDLE) begin
            errors++;
            $display("FAIL gap_ncs: falls=%0d high=%0d required 2 and >=%0d",
                     ncs_falls - f0, last_high_run, CS_IDLE);
        end
        checks++;
        if (first_mosi !== exp_first) begin
            errors++;
            $display("FAIL gap_first_bit: MOSI=%b required %b", first_mosi, exp_first);
        end
        checks++;
        if (rx_cnt - r0 !== 2 || rx_log[r0[7:0]] !== {1'b1, 8'h01}
            || rx_log[8'(r0 + 1)] !== {1'b1, 8'h01}) begin
            errors++;
            $display("FAIL gap_rx: count=%0d bytes=%h %h required 2, 101 101",
                     rx_cnt - r0, rx_log[r0[7:0]], rx_log[8'(r0 + 1)]);
        end
    endtask

    task automatic test_reset_mid();
        int r0, n;
        r0 = rx_cnt;
        push(8'hA5, 1'b1);
        bus.tx_valid = 1'b0;
        n = 0;
        while (bus.SCK !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        nreset = 1'b0;
        #1;
        checks++;
        if ({bus.nCS, bus.SCK, bus.MOSI, bus.busy} !== 4'b1000 || n >= 100) begin
            errors++;
            $display("FAIL reset_mid_pins: nCS/SCK/MOSI/busy=%b (wait %0d) required 1000",
                     {bus.nCS, bus.SCK, bus.MOSI, bus.busy}, n);
        end
        checks++;
        if (bus.rx_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_mid_rxdata: rx_data=%h required 00", bus.rx_data);
        end
        repeat (2) step();
        nreset = 1'b1;
        repeat (60) step();
        checks++;
        if (rx_cnt - r0 !== 0 || bus.busy !== 1'b0 || bus.tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_after: rx strobes=%0d busy=%b ready=%b required 0,0,1",
                     rx_cnt - r0, bus.busy, bus.tx_ready);
        end
    endtask

    // ---------------- Sequence --------------------------------------------
    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_slave();
        test_gap();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
